rgb_frame_pwm: RTL and testbench

//   Downstream consumer of the UART receiver byte stream. Parses 5-byte colour

---
 rtl/rgb_frame_pwm.sv | 143 ++++++++++++++
 tb/tb_rgb_frame_pwm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_pwm.sv
// Colour frame parser for the UART byte stream plus three phase-aligned 8-bit PWM channels.
// Accepted frames update duty_*; the PWM picks up new duties only at the period boundary.
module rgb_frame_pwm #(
   parameter logic [7:0]  HEADER      = 8'hAA,
   parameter int unsigned PRESCALE    = 4,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [7:0] duty_r,
   output logic [7:0] duty_g,
   output logic [7:0] duty_b,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned GW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_R,
      GET_G,
      GET_B,
      GET_C
   } state_t;

   state_t        state;
   logic [7:0]    shadow_r;
   logic [7:0]    shadow_g;
   logic [7:0]    shadow_b;
   logic [GW-1:0] gap_cnt;

   logic [PW-1:0] presc;
   logic [7:0]    pwm_cnt;
   logic [7:0]    active_r;
   logic [7:0]    active_g;
   logic [7:0]    active_b;

   logic [7:0]    frame_chk;
   assign frame_chk = shadow_r ^ shadow_g ^ shadow_b;

   // Frame parser: a byte always takes priority over the inter-byte timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shadow_r  <= '0;
         shadow_g  <= '0;
         shadow_b  <= '0;
         gap_cnt   <= '0;
         duty_r    <= '0;
         duty_g    <= '0;
         duty_b    <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         if (rx_valid) begin
            gap_cnt <= '0;
            case (state)
               IDLE: begin
                  if (rx_data == HEADER) begin
                     state <= GET_R;
                  end
               end
               GET_R: begin
                  shadow_r <= rx_data;
                  state    <= GET_G;
               end
               GET_G: begin
                  shadow_g <= rx_data;
                  state    <= GET_B;
               end
               GET_B: begin
                  shadow_b <= rx_data;
                  state    <= GET_C;
               end
               GET_C: begin
                  if (rx_data == frame_chk) begin
                     duty_r   <= shadow_r;
                     duty_g   <= shadow_g;
                     duty_b   <= shadow_b;
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (gap_cnt == GAP_LAST) begin
               state     <= IDLE;
               frame_err <= 1'b1;
               gap_cnt   <= '0;
               shadow_r  <= '0;
               shadow_g  <= '0;
               shadow_b  <= '0;
            end else begin
               gap_cnt <= gap_cnt + GW'(1);
            end
         end
      end
   end

   // PWM timebase; active duties reload only on the 255->0 wrap so a period is never split.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc    <= '0;
         pwm_cnt  <= '0;
         active_r <= '0;
         active_g <= '0;
         active_b <= '0;
         pwm_r    <= 1'b0;
         pwm_g    <= 1'b0;
         pwm_b    <= 1'b0;
      end else begin
         pwm_r <= (pwm_cnt < active_r);
         pwm_g <= (pwm_cnt < active_g);
         pwm_b <= (pwm_cnt < active_b);
         if (presc == PRESC_LAST) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) begin
               active_r <= duty_r;
               active_g <= duty_g;
               active_b <= duty_b;
            end
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_rgb_frame_pwm.sv
// Randomised bench for rgb_frame_pwm: a frame-level reference model feeds a scoreboard of
// expected frame_ok/frame_err pulses, and PWM high time is checked per 256-count period.
module tb_rgb_frame_pwm;

   localparam int unsigned P   = 4;
   localparam int unsigned TO  = 48;
   localparam int unsigned PER = 256 * P;
   localparam logic [7:0]  HDR = 8'hAA;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       frame_ok, frame_err, pwm_r, pwm_g, pwm_b;
   logic [7:0] duty_r, duty_g, duty_b;

   always #5 clk = ~clk;

   rgb_frame_pwm #(.HEADER(HDR), .PRESCALE(P), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_ok(frame_ok), .frame_err(frame_err),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b)
   );

   typedef struct {
      bit          ok;
      logic [7:0]  r, g, b;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int unsigned tests = 0;
   int unsigned fails = 0;

   // reference model state
   bit          in_frame = 1'b0;
   logic [7:0]  fbuf[$];
   int unsigned idle = 0;
   logic [7:0]  dm_r = '0, dm_g = '0, dm_b = '0;
   logic [7:0]  am_r = '0, am_g = '0, am_b = '0;
   int unsigned n = 0;
   int unsigned edge_n = 0;
   bit          rst_edge = 1'b1;

   // monitor state
   int unsigned acc_r = 0, acc_g = 0, acc_b = 0;
   logic [7:0]  w_r = '0, w_g = '0, w_b = '0;

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, req);
      end
   endtask

   // One clock edge of stimulus plus the matching step of the reference model.
   task automatic tick(input bit r, input bit v, input logic [7:0] d);
      bit ok;
      reset    = r;
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      edge_n++;
      rst_edge = r;
      if (r) begin
         in_frame = 1'b0;
         fbuf.delete();
         idle = 0;
         {dm_r, dm_g, dm_b} = '0;
         {am_r, am_g, am_b} = '0;
         n = 0;
      end else begin
         n++;
         if (n % PER == 0) {am_r, am_g, am_b} = {dm_r, dm_g, dm_b};
         if (v) begin
            idle = 0;
            if (!in_frame) begin
               if (d == HDR) begin
                  in_frame = 1'b1;
                  fbuf.delete();
               end
            end else begin
               fbuf.push_back(d);
               if (fbuf.size() == 4) begin
                  ok = (fbuf[3] == (fbuf[0] ^ fbuf[1] ^ fbuf[2]));
                  if (ok) {dm_r, dm_g, dm_b} = {fbuf[0], fbuf[1], fbuf[2]};
                  sb.push_back('{ok, dm_r, dm_g, dm_b, edge_n});
                  in_frame = 1'b0;
                  fbuf.delete();
               end
            end
         end else if (in_frame) begin
            idle++;
            if (idle == TO) begin
               sb.push_back('{1'b0, dm_r, dm_g, dm_b, edge_n});
               in_frame = 1'b0;
               fbuf.delete();
               idle = 0;
            end
         end
      end
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int unsigned gap);
      tick(1'b0, 1'b1, b);
      repeat (gap) tick(1'b0, 1'b0, 8'h00);
   endtask

   task automatic idle_cycles(input int unsigned k);
      repeat (k) tick(1'b0, 1'b0, 8'h00);
   endtask

   function automatic int unsigned pick_gap();
      case ($urandom_range(0, 15))
         0:       return TO - 1;
         1:       return TO;
         default: return $urandom_range(0, 3);
      endcase
   endfunction

   function automatic logic [7:0] pick_byte();
      case ($urandom_range(0, 9))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return HDR;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Monitor: pops the scoreboard on each pulse and tallies PWM high time per period.
   always @(negedge clk) begin
      exp_t e;
      if (rst_edge) begin
         check("reset_outputs",
               32'({frame_ok, frame_err, pwm_r, pwm_g, pwm_b, duty_r, duty_g, duty_b}), 0);
         acc_r = 0; acc_g = 0; acc_b = 0;
         {w_r, w_g, w_b} = '0;
      end else begin
         if (frame_ok || frame_err) begin
            if (frame_ok && frame_err) check("ok_err_together", 1, 0);
            if (sb.size() == 0) begin
               check("unexpected_pulse", 32'({frame_ok, frame_err}), 0);
            end else begin
               e = sb.pop_front();
               check("pulse_kind_ok", 32'(frame_ok), 32'(e.ok));
               check("pulse_edge", edge_n, e.at);
               check("duty_r", 32'(duty_r), 32'(e.r));
               check("duty_g", 32'(duty_g), 32'(e.g));
               check("duty_b", 32'(duty_b), 32'(e.b));
            end
         end else if (sb.size() > 0 && sb[0].at <= edge_n) begin
            e = sb.pop_front();
            check(e.ok ? "missing_frame_ok" : "missing_frame_err",
                  32'({frame_ok, frame_err}), e.ok ? 2 : 1);
         end
         acc_r += 32'(pwm_r);
         acc_g += 32'(pwm_g);
         acc_b += 32'(pwm_b);
         if (n % PER == 0) begin
            check("pwm_r_high", acc_r, 32'(w_r) * P);
            check("pwm_g_high", acc_g, 32'(w_g) * P);
            check("pwm_b_high", acc_b, 32'(w_b) * P);
            acc_r = 0; acc_g = 0; acc_b = 0;
            {w_r, w_g, w_b} = {am_r, am_g, am_b};
         end
      end
   end

   initial begin
      logic [7:0] fr[5];
      logic [7:0] c;

      repeat (3) tick(1'b1, 1'b0, 8'h00);

      // good frame, back-to-back bytes
      send(HDR, 0); send(8'h80, 0); send(8'h40, 0); send(8'hFF, 0); send(8'h3F, 3);
      idle_cycles(2 * PER);

      // bad checksum keeps duty
      send(HDR, 1); send(8'h10, 1); send(8'h20, 1); send(8'h30, 1); send(8'h01, 4);
      // junk before header, header value as data would be fine too
      send(8'h55, 2); send(8'h12, 2);
      send(HDR, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h00, 5);
      idle_cycles(PER);

      // inter-byte timeout, then recovery
      send(HDR, 0); send(8'h10, TO);
      send(HDR, TO - 1); send(8'h05, TO - 1); send(8'h06, 0); send(8'h07, 0); send(8'h04, 3);
      // extremes, with header byte used as data
      send(HDR, 0); send(8'h00, 0); send(HDR, 0); send(8'hFF, 0); send(8'h55, 2);
      idle_cycles(PER + 100);

      // randomised frames with random gaps and junk
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 255)), pick_gap());
         fr[0] = HDR;
         fr[1] = pick_byte();
         fr[2] = pick_byte();
         fr[3] = pick_byte();
         c = fr[1] ^ fr[2] ^ fr[3];
         if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
         fr[4] = c;
         for (int i = 0; i < 5; i++) send(fr[i], (i == 4) ? 0 : pick_gap());
         idle_cycles($urandom_range(0, PER / 2));
      end
      idle_cycles(PER + TO);

      // reset in the middle of a frame drops it silently
      send(HDR, 0); send(8'h10, 2);
      tick(1'b1, 1'b0, 8'h00);
      idle_cycles(TO + 10);
      send(HDR, 0); send(8'h21, 0); send(8'h42, 0); send(8'h84, 0); send(8'hE7, 0);
      idle_cycles(2 * PER + 10);

      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
